// File: rtl/spi_bridge_pkg.sv
// rtl/spi_bridge_pkg.sv - shared types and response codes for the AXI-to-APB bridge
// Purpose: FSM state encoding and AXI response codes used by spi_axi2apb_bridge.
// Contents: state_t (IDLE, SETUP, ACCESS, WRESP, RRESP); OKAY, SLVERR, DECERR.
package spi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    WRESP  = 3'd3,
    RRESP  = 3'd4
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/apb_intf.sv
// rtl/apb_intf.sv - APB bus bundle between the bridge and the SPI core APB splitter
// Purpose: groups the APB request/response signals of one APB segment.
// Signals: psel, penable, pwrite, paddr[ADDR_W], pprot[3], pwdata[DATA_W],
//          pstrb[DATA_W/8] (requester side); pready, prdata[DATA_W], pslverr (completer side).
// Modports: master drives the request side, slave drives the response side.
interface apb_intf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [2:0]            pprot;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic                  pready;
  logic [DATA_W-1:0]     prdata;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pprot, pwdata, pstrb,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/spi_axi2apb_bridge.sv
// rtl/spi_axi2apb_bridge.sv - AXI4-Lite slave to APB master bridge for the SPI core register file
// Purpose: accepts one AXI4-Lite read or write at a time and replays it as a single
//          APB transfer, returning the APB completion status as the AXI response.
// Ports:   clk, rstn (async active-low)
//          AW: awvalid/awready, awaddr, awprot   W: wvalid/wready, wdata, wstrb
//          B:  bvalid/bready, bresp              AR: arvalid/arready, araddr, arprot
//          R:  rvalid/rready, rdata, rresp       apb: apb_intf.master
module spi_axi2apb_bridge
  import spi_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [2:0]          awprot,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                bvalid,
  input  logic                bready,
  output logic [1:0]          bresp,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [2:0]          arprot,
  output logic                rvalid,
  input  logic                rready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  apb_intf.master             apb
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t                state;
  state_t                state_nx;
  logic                  prefer_wr;
  logic [ADDR_W-1:0]     addr_q;
  logic [2:0]            prot_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wstrb_q;
  logic                  write_q;
  logic [DATA_W-1:0]     rdata_q;
  logic [1:0]            resp_q;
  logic [CNT_W-1:0]      tcnt;

  logic                  wr_elig;
  logic                  rd_elig;
  logic                  grant_wr;
  logic                  grant_rd;
  logic                  timed_out;
  logic                  psel_c;
  logic                  penable_c;

  // A write needs both AW and W so address and data are always taken together.
  assign wr_elig  = awvalid & wvalid;
  assign rd_elig  = arvalid;
  // On contention the direction that did not win last time goes first.
  assign grant_wr = wr_elig & (~rd_elig | prefer_wr);
  assign grant_rd = rd_elig & (~wr_elig | ~prefer_wr);

  // tcnt counts completed wait cycles; this is the last one allowed.
  generate
    if (TIMEOUT > 0) begin : g_timeout
      assign timed_out = (tcnt == CNT_W'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timed_out = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    awready   = 1'b0;
    wready    = 1'b0;
    arready   = 1'b0;
    psel_c    = 1'b0;
    penable_c = 1'b0;
    bvalid    = 1'b0;
    rvalid    = 1'b0;
    case (state)
      IDLE: begin
        // Readies are gated by rstn so nothing looks accepted while held in reset.
        if (rstn && grant_wr) begin
          awready  = 1'b1;
          wready   = 1'b1;
          state_nx = SETUP;
        end else if (rstn && grant_rd) begin
          arready  = 1'b1;
          state_nx = SETUP;
        end
      end
      SETUP: begin
        // pready here belongs to nobody and is deliberately not looked at.
        psel_c   = 1'b1;
        state_nx = ACCESS;
      end
      ACCESS: begin
        psel_c    = 1'b1;
        penable_c = 1'b1;
        if (apb.pready || timed_out) begin
          state_nx = write_q ? WRESP : RRESP;
        end
      end
      WRESP: begin
        bvalid = 1'b1;
        if (bready) state_nx = IDLE;
      end
      RRESP: begin
        rvalid = 1'b1;
        if (rready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prefer_wr <= 1'b1;
      addr_q    <= '0;
      prot_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= OKAY;
      tcnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_wr) begin
            addr_q    <= awaddr;
            prot_q    <= awprot;
            wdata_q   <= wdata;
            wstrb_q   <= wstrb;
            write_q   <= 1'b1;
            prefer_wr <= 1'b0;
          end else if (grant_rd) begin
            // Reads carry zero data/strobes so the APB side never sees stale write data.
            addr_q    <= araddr;
            prot_q    <= arprot;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            prefer_wr <= 1'b1;
          end
        end
        SETUP: tcnt <= '0;
        ACCESS: begin
          if (apb.pready) begin
            resp_q <= apb.pslverr ? SLVERR : OKAY;
            if (!write_q) rdata_q <= apb.prdata;
          end else if (timed_out) begin
            resp_q <= DECERR;
            if (!write_q) rdata_q <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign apb.psel    = psel_c;
  assign apb.penable = penable_c;
  assign apb.pwrite  = write_q;
  assign apb.paddr   = addr_q;
  assign apb.pprot   = prot_q;
  assign apb.pwdata  = wdata_q;
  assign apb.pstrb   = wstrb_q;

  assign bresp = resp_q;
  assign rresp = resp_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_spi_axi2apb_bridge.sv
// tb/tb_spi_axi2apb_bridge.sv - self-checking bench for spi_axi2apb_bridge
module tb_spi_axi2apb_bridge;

  logic        clk;
  logic        rstn;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  // APB completer model controls
  int          wait_cfg = 0;
  logic        hang = 1'b0;
  logic        setup_rdy = 1'b0;
  logic [31:0] prdata_cfg = '0;
  logic        pslverr_cfg = 1'b0;

  // Monitor state (written only by the monitor process)
  int          acc_cnt = 0;
  int          last_acc_len = 0;
  int          log_n = 0;
  int          mon_bad = 0;
  logic [71:0] snap = '0;
  logic        log_pwrite [0:63];
  logic [31:0] log_paddr  [0:63];
  logic [31:0] log_pwdata [0:63];
  logic [3:0]  log_pstrb  [0:63];
  logic [2:0]  log_pprot  [0:63];

  int checks = 0;
  int errors = 0;

  apb_intf #(.ADDR_W(32), .DATA_W(32)) apb_if ();

  spi_axi2apb_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rstn(rstn),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .apb(apb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign apb_if.pready  = (apb_if.psel && !apb_if.penable && setup_rdy) ||
                          (apb_if.psel && apb_if.penable && !hang && (acc_cnt == wait_cfg));
  assign apb_if.prdata  = prdata_cfg;
  assign apb_if.pslverr = pslverr_cfg;

  wire [71:0] apb_req = {apb_if.paddr, apb_if.pwrite, apb_if.pwdata, apb_if.pstrb, apb_if.pprot};

  always @(posedge clk) begin
    if (apb_if.psel && apb_if.penable) begin
      if (apb_req !== snap) mon_bad <= mon_bad + 1;
      if (apb_if.pready) begin
        if (log_n < 64) begin
          log_pwrite[log_n] <= apb_if.pwrite;
          log_paddr[log_n]  <= apb_if.paddr;
          log_pwdata[log_n] <= apb_if.pwdata;
          log_pstrb[log_n]  <= apb_if.pstrb;
          log_pprot[log_n]  <= apb_if.pprot;
          log_n <= log_n + 1;
        end
        last_acc_len <= acc_cnt + 1;
        acc_cnt <= 0;
      end else begin
        acc_cnt <= acc_cnt + 1;
      end
    end else begin
      acc_cnt <= 0;
      if (apb_if.psel) snap <= apb_req;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s: cycle budget expired, got no handshake, expected one", name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [2:0] p, output logic [1:0] resp);
    int n;
    resp = 2'bxx;
    @(negedge clk);
    awaddr = a; awprot = p; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    #1;
    while (!(awready && wready) && n < 100) begin @(negedge clk); #1; n++; end
    if (n >= 100) begin
      fail_bound("aw_accept");
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      fail_bound("b_valid");
      return;
    end
    resp = bresp;
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [2:0] p,
                          output logic [1:0] resp, output logic [31:0] data);
    int n;
    resp = 2'bxx;
    data = 'x;
    @(negedge clk);
    araddr = a; arprot = p; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    #1;
    while (!arready && n < 100) begin @(negedge clk); #1; n++; end
    if (n >= 100) begin
      fail_bound("ar_accept");
      arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      fail_bound("r_valid");
      return;
    end
    resp = rresp;
    data = rdata;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [2:0]  prot;
    int          wait_c;
    logic        setup_rdy;
    logic [31:0] prdata;
    logic        slverr;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  initial begin : stim
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  resp0;
    int          n, acc, base, aw_left, ar_left, bad;
    logic        wacc, racc;
    logic [31:0] exp_pw;
    logic [3:0]  exp_ps;

    vecs[0] = '{1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 4'hF, 3'b000, 0, 1'b0, 32'h0,         1'b0, 2'b00, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0800, 32'h0,         4'h0, 3'b000, 3, 1'b0, 32'h1234_5678, 1'b1, 2'b10, 32'h1234_5678};
    vecs[2] = '{1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'h3, 3'b010, 1, 1'b0, 32'h0,         1'b1, 2'b10, 32'h0};
    vecs[3] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 3'b101, 0, 1'b0, 32'hCAFE_F00D, 1'b0, 2'b00, 32'hCAFE_F00D};
    vecs[4] = '{1'b1, 32'h0000_0008, 32'h0000_0001, 4'h8, 3'b001, 2, 1'b1, 32'h0,         1'b0, 2'b00, 32'h0};
    vecs[5] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 3'b000, 7, 1'b0, 32'h0BAD_F00D, 1'b0, 2'b00, 32'h0BAD_F00D};

    rstn = 1'b0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    awaddr = 32'h1; araddr = 32'h2; awprot = 3'b111; arprot = 3'b111;
    wdata = 32'hFFFF_FFFF; wstrb = 4'hF; bready = 1'b0; rready = 1'b0;

    // Reset state, with every request valid held high
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready_valid", {awready, wready, arready, bvalid, rvalid, apb_if.psel, apb_if.penable, apb_if.pwrite}, 0);
    chk("rst_paddr", apb_if.paddr, 0);
    chk("rst_pwdata", apb_if.pwdata, 0);
    chk("rst_pstrb_pprot", {apb_if.pstrb, apb_if.pprot}, 0);
    chk("rst_resp", {bresp, rresp}, 0);
    chk("rst_rdata", rdata, 0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // Minimum-latency write, cycle by cycle
    @(negedge clk);
    awaddr = 32'h40; awprot = 3'b000; wdata = 32'hA5A5_A5A5; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b0; bready = 1'b0;
    #1;
    chk("lat_accept", {awready, wready, arready}, 3'b110);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("lat_setup", {apb_if.psel, apb_if.penable, awready}, 3'b100);
    @(posedge clk); #1;
    chk("lat_access", {apb_if.psel, apb_if.penable, apb_if.pwrite}, 3'b111);
    @(posedge clk); #1;
    chk("lat_bvalid", {bvalid, bresp, apb_if.psel, apb_if.penable}, 5'b10000);
    bready = 1'b1;
    @(posedge clk); #1;
    chk("lat_b_done", bvalid, 0);

    // Table-driven single transactions
    for (int i = 0; i < 6; i++) begin
      wait_cfg = vecs[i].wait_c;
      setup_rdy = vecs[i].setup_rdy;
      prdata_cfg = vecs[i].prdata;
      pslverr_cfg = vecs[i].slverr;
      base = log_n;
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].prot, resp);
      end else begin
        axi_read(vecs[i].addr, vecs[i].prot, resp, data);
        chk($sformatf("v%0d_rdata", i), data, vecs[i].exp_rdata);
      end
      chk($sformatf("v%0d_resp", i), resp, vecs[i].exp_resp);
      chk($sformatf("v%0d_apb_count", i), log_n - base, 1);
      exp_pw = vecs[i].wr ? vecs[i].wdata : 32'h0;
      exp_ps = vecs[i].wr ? vecs[i].wstrb : 4'h0;
      chk($sformatf("v%0d_pwrite", i), log_pwrite[base], vecs[i].wr);
      chk($sformatf("v%0d_paddr", i), log_paddr[base], vecs[i].addr);
      chk($sformatf("v%0d_pwdata", i), log_pwdata[base], exp_pw);
      chk($sformatf("v%0d_pstrb", i), log_pstrb[base], exp_ps);
      chk($sformatf("v%0d_pprot", i), log_pprot[base], vecs[i].prot);
      chk($sformatf("v%0d_access_len", i), last_acc_len, vecs[i].wait_c + 1);
    end
    setup_rdy = 1'b0;
    pslverr_cfg = 1'b0;

    // Timeout: completer never answers
    hang = 1'b1;
    @(negedge clk);
    araddr = 32'h20; arprot = 3'b000; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    #1;
    while (!arready && n < 100) begin @(negedge clk); #1; n++; end
    if (n >= 100) fail_bound("to_accept");
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0; acc = 0;
    while (!rvalid && n < 100) begin
      @(negedge clk);
      if (apb_if.psel && apb_if.penable) acc++;
      n++;
    end
    if (n >= 100) fail_bound("to_rvalid");
    chk("to_access_cycles", acc, 8);
    chk("to_rresp", rresp, 2'b11);
    chk("to_rdata", rdata, 0);
    chk("to_psel", {apb_if.psel, apb_if.penable}, 0);
    @(posedge clk); #1;
    hang = 1'b0;
    wait_cfg = 0;
    prdata_cfg = 32'h0000_55AA;
    axi_read(32'h24, 3'b000, resp, data);
    chk("post_to_resp", resp, 2'b00);
    chk("post_to_rdata", data, 32'h0000_55AA);

    // B channel stall with a competing write and a pending read
    pslverr_cfg = 1'b1;
    prdata_cfg = 32'h0F0F_0F0F;
    @(negedge clk);
    awaddr = 32'h30; awprot = 3'b000; wdata = 32'h1111_2222; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    #1;
    while (!awready && n < 100) begin @(negedge clk); #1; n++; end
    if (n >= 100) fail_bound("stall_accept");
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) fail_bound("stall_bvalid");
    #1;
    resp0 = bresp;
    awaddr = 32'h34; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h38; arvalid = 1'b1; rready = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall_bvalid_c%0d", c), bvalid, 1);
      chk($sformatf("stall_bresp_c%0d", c), bresp, 2'b10);
      chk($sformatf("stall_awready_c%0d", c), awready, 0);
      chk($sformatf("stall_arready_c%0d", c), arready, 0);
      @(negedge clk); #1;
    end
    chk("stall_bresp_first", resp0, 2'b10);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk); #1;
    chk("stall_read_wins", {arready, awready}, 2'b10);
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) fail_bound("stall_rvalid");
    chk("stall_read_data", rdata, 32'h0F0F_0F0F);
    @(posedge clk); #1;
    pslverr_cfg = 1'b0;
    bready = 1'b1;

    // Simultaneous AW/W/AR, twice, right after reset
    do_reset();
    base = log_n;
    aw_left = 2; ar_left = 2;
    @(negedge clk);
    awaddr = 32'h100; wdata = 32'h0000_0100; wstrb = 4'hF; araddr = 32'h200;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    n = 0;
    while ((aw_left > 0 || ar_left > 0) && n < 200) begin
      #1;
      wacc = awready && wready;
      racc = arready;
      @(posedge clk); #1;
      if (wacc) begin
        aw_left--;
        if (aw_left == 0) begin awvalid = 1'b0; wvalid = 1'b0; end
      end
      if (racc) begin
        ar_left--;
        if (ar_left == 0) arvalid = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_bound("order_accepts");
    n = 0;
    while (log_n < base + 4 && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("order_count", log_n - base, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("order_dir_%0d", k), log_pwrite[base + k], (k % 2 == 0) ? 1 : 0);
    end

    // Reset asserted in the middle of ACCESS
    hang = 1'b1;
    @(negedge clk);
    araddr = 32'h300; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    #1;
    while (!arready && n < 100) begin @(negedge clk); #1; n++; end
    if (n >= 100) fail_bound("rst_mid_accept");
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!(apb_if.psel && apb_if.penable) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) fail_bound("rst_mid_access");
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_mid_drop", {apb_if.psel, apb_if.penable, rvalid, arready}, 0);
    chk("rst_mid_paddr", apb_if.paddr, 0);
    @(negedge clk);
    rstn = 1'b1;
    hang = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (rvalid || apb_if.psel) bad = 1;
    end
    chk("rst_mid_no_resp", bad, 0);
    base = log_n;
    axi_write(32'h0000_0044, 32'h5A5A_0001, 4'hF, 3'b000, resp);
    chk("rst_post_resp", resp, 2'b00);
    chk("rst_post_count", log_n - base, 1);
    chk("rst_post_paddr", log_paddr[base], 32'h0000_0044);
    chk("rst_post_pwdata", log_pwdata[base], 32'h5A5A_0001);

    chk("apb_req_stable_in_access", mon_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
